// File: rtl/bin2bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
// Optional feature macro used by the top: BIN2BCD_LEADING_ZERO_BLANK_EN.
package bin2bcd_pkg;

    // Legacy state encodings, kept as plain constants for older code that compares raw bits
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SHIFT = ST_SHIFT,
        DONE  = ST_DONE
    } state_e;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_NINE = 4'h9;

    // Each BCD digit absorbs a bit more than three binary bits, so ceil(width/3)
    // digits always hold the full unsigned value.
    function automatic int int_digits(input int width);
        return (width + 2) / 3;
    endfunction

endpackage

// File: rtl/bcd_add3_digit.sv
// One double-dabble correction cell: a digit of 5 or more gets +3 so that the
// following left shift carries correctly into the next decimal digit.
module bcd_add3_digit
    import bin2bcd_pkg::*;
(
    input  bcd_digit_t digit_in,
    output bcd_digit_t digit_out
);

    // Pre-shift correction; values 5..9 map to 8..12, never past 4 bits
    always_comb begin
        digit_out = digit_in;
        if (digit_in >= 4'd5) begin
            digit_out = digit_in + 4'd3;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 converter: unsigned binary in, packed BCD out, one
// bit per clock. Results are registered and held until the next completion;
// values above 10^DIGITS-1 saturate to all nines with overflow set.
// Optional: define BIN2BCD_LEADING_ZERO_BLANK_EN to add the blank_mask output.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [WIDTH-1:0]      in_value,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow,
    output logic                  busy
`ifdef BIN2BCD_LEADING_ZERO_BLANK_EN
    ,
    output logic [DIGITS-1:0]     blank_mask
`endif
);

    localparam int INT_DIGITS = int_digits(WIDTH);
    localparam int ACC_W      = 4 * INT_DIGITS;
    localparam int OUT_W      = 4 * DIGITS;
    localparam int EXT_DIGITS = (INT_DIGITS > DIGITS) ? INT_DIGITS : DIGITS;
    localparam int EXT_W      = 4 * EXT_DIGITS;
    localparam int CNT_W      = $clog2(WIDTH + 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   sh_q, sh_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [OUT_W-1:0]   bcd_q, bcd_d;
    logic               ovf_q, ovf_d;

    logic [ACC_W-1:0]       acc_adj;
    logic [ACC_W+WIDTH-1:0] shifted;
    logic [ACC_W-1:0]       acc_shift;
    logic [WIDTH-1:0]       sh_shift;
    logic [EXT_W-1:0]       acc_ext;
    logic [OUT_W-1:0]       bcd_n;
    logic                   ovf_n;

    genvar g;
    for (g = 0; g < INT_DIGITS; g++) begin : g_add3
        bcd_add3_digit u_add3 (
            .digit_in  (acc_q[4*g +: 4]),
            .digit_out (acc_adj[4*g +: 4])
        );
    end

    // The accumulator and the remaining binary bits move left as one word
    assign shifted   = {acc_adj, sh_q} << 1;
    assign acc_shift = shifted[ACC_W+WIDTH-1:WIDTH];
    assign sh_shift  = shifted[WIDTH-1:0];

    // Zero-extend so digit selects stay in range even when DIGITS > INT_DIGITS
    assign acc_ext = EXT_W'(acc_shift);

    // Saturate and present the low digits of the post-shift accumulator
    always_comb begin
        ovf_n = 1'b0;
        bcd_n = '0;
        for (int i = DIGITS; i < EXT_DIGITS; i++) begin
            if (acc_ext[4*i +: 4] != 4'd0) begin
                ovf_n = 1'b1;
            end
        end
        for (int i = 0; i < DIGITS; i++) begin
            bcd_n[4*i +: 4] = ovf_n ? BCD_NINE : acc_ext[4*i +: 4];
        end
    end

`ifdef BIN2BCD_LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] blank_q, blank_d;
    logic [DIGITS-1:0] blank_n;
    logic              upper_zero;

    // A digit blanks when it and every presented digit above it are zero; digit 0 always shows
    always_comb begin
        blank_n    = '0;
        upper_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            upper_zero = upper_zero && (bcd_n[4*i +: 4] == 4'd0);
            blank_n[i] = upper_zero && !ovf_n;
        end
    end
`endif

    // Next-state and datapath control for IDLE -> SHIFT x WIDTH -> DONE
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
`ifdef BIN2BCD_LEADING_ZERO_BLANK_EN
        blank_d = blank_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sh_d    = in_value;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                acc_d = acc_shift;
                sh_d  = sh_shift;
                cnt_d = cnt_q + CNT_W'(1);
                // Last iteration: the result registers load on the edge entering DONE
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = DONE;
                    bcd_d   = bcd_n;
                    ovf_d   = ovf_n;
`ifdef BIN2BCD_LEADING_ZERO_BLANK_EN
                    blank_d = blank_n;
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any conversion in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sh_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
`ifdef BIN2BCD_LEADING_ZERO_BLANK_EN
            blank_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
`ifdef BIN2BCD_LEADING_ZERO_BLANK_EN
            blank_q <= blank_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign bcd_out   = bcd_q;
    assign overflow  = ovf_q;
`ifdef BIN2BCD_LEADING_ZERO_BLANK_EN
    assign blank_mask = blank_q;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq with randomized operands and a decimal
// reference model. Build with BIN2BCD_LEADING_ZERO_BLANK_EN to cover blank_mask.
module tb_bin2bcd_seq;

    localparam int WIDTH  = 16;
    localparam int DIGITS = 4;
    localparam int MAXV   = 9999;
    localparam int LAT    = WIDTH + 1;

    logic                 clk;
    logic                 rst;
    logic                 in_valid;
    logic [WIDTH-1:0]     in_value;
    logic                 in_ready;
    logic                 out_valid;
    logic [4*DIGITS-1:0]  bcd_out;
    logic                 overflow;
    logic                 busy;
`ifdef BIN2BCD_LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0]    blank_mask;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    int n_pulse = 0;

    bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_value   (in_value),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .bcd_out    (bcd_out),
        .overflow   (overflow),
        .busy       (busy)
`ifdef BIN2BCD_LEADING_ZERO_BLANK_EN
        ,
        .blank_mask (blank_mask)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (out_valid === 1'b1) n_pulse++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Decimal digits by plain division; saturate to all nines above the display range
    function automatic logic [4*DIGITS-1:0] ref_bcd(input int v);
        logic [4*DIGITS-1:0] r;
        int rem;
        r = '0;
        if (v > MAXV) begin
            for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'h9;
        end else begin
            rem = v;
            for (int i = 0; i < DIGITS; i++) begin
                r[4*i +: 4] = 4'(rem % 10);
                rem = rem / 10;
            end
        end
        return r;
    endfunction

    // Digit i blanks when the value has no more than i significant decimal digits
    function automatic logic [DIGITS-1:0] ref_blank(input int v);
        logic [DIGITS-1:0] m;
        int p;
        m = '0;
        p = 10;
        if (v <= MAXV) begin
            for (int i = 1; i < DIGITS; i++) begin
                m[i] = (v < p);
                p = p * 10;
            end
        end
        return m;
    endfunction

    task automatic check_outputs(input string tag, input int v);
        check({tag, ".bcd"}, 32'(bcd_out), 32'(ref_bcd(v)));
        check({tag, ".ovf"}, 32'(overflow), 32'(v > MAXV));
`ifdef BIN2BCD_LEADING_ZERO_BLANK_EN
        check({tag, ".blank"}, 32'(blank_mask), 32'(ref_blank(v)));
`endif
    endtask

    // Accept one operand, wait (bounded) for the result and check timing and value
    task automatic run_conv(input int v, input string tag, input bit full);
        int lat;
        int p0;
        bit ready_leak;
        p0 = n_pulse;
        @(negedge clk);
        in_value = WIDTH'(v);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        ready_leak = 1'b0;
        while (out_valid !== 1'b1 && lat < 3 * LAT) begin
            if (in_ready !== 1'b0 || busy !== 1'b1) ready_leak = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, ".lat"}, 32'(lat), 32'(LAT));
        check_outputs(tag, v);
        if (full) begin
            check({tag, ".rdy_low"}, 32'(ready_leak || in_ready !== 1'b0), 32'd0);
            @(posedge clk);
            #1;
            check({tag, ".vld_drop"}, 32'(out_valid), 32'd0);
            check({tag, ".rdy_back"}, 32'(in_ready), 32'd1);
            check_outputs({tag, ".held"}, v);
            check({tag, ".pulses"}, 32'(n_pulse - p0), 32'd1);
        end else begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int v;
        int p0;
        int lat;

        rst      = 1'b1;
        in_valid = 1'b0;
        in_value = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.ready", 32'(in_ready), 32'd1);
        check("rst.vld",   32'(out_valid), 32'd0);
        check("rst.bcd",   32'(bcd_out), 32'd0);
        check("rst.ovf",   32'(overflow), 32'd0);
        check("rst.busy",  32'(busy), 32'd0);
`ifdef BIN2BCD_LEADING_ZERO_BLANK_EN
        check("rst.blank", 32'(blank_mask), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        run_conv(1234,  "c1234",  1'b1);
        run_conv(0,     "c0",     1'b1);
        run_conv(9999,  "c9999",  1'b1);
        run_conv(10000, "c10000", 1'b1);
        run_conv(65535, "cffff",  1'b1);
        run_conv(9,     "c9",     1'b0);
        run_conv(10,    "c10",    1'b0);

        // Second request while busy and a request during DONE are both dropped
        p0 = n_pulse;
        @(negedge clk);
        in_value = 16'h0007;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        in_value = 16'h0063;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 3 * LAT) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_outputs("ign", 7);
        in_value = 16'h0063;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("ign.done_req", 32'(in_ready), 32'd1);
        repeat (3 * LAT) @(posedge clk);
        #1;
        check("ign.pulses", 32'(n_pulse - p0), 32'd1);
        check("ign.idle", 32'(busy), 32'd0);
        check_outputs("ign.held", 7);

        // Asynchronous reset mid-conversion aborts with no result
        p0 = n_pulse;
        @(negedge clk);
        in_value = 16'h1234;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort.ready", 32'(in_ready), 32'd1);
        check("abort.busy",  32'(busy), 32'd0);
        check("abort.bcd",   32'(bcd_out), 32'd0);
        check("abort.ovf",   32'(overflow), 32'd0);
`ifdef BIN2BCD_LEADING_ZERO_BLANK_EN
        check("abort.blank", 32'(blank_mask), 32'd0);
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2 * LAT) @(posedge clk);
        #1;
        check("abort.pulses", 32'(n_pulse - p0), 32'd0);
        check("abort.bcd_after", 32'(bcd_out), 32'd0);
        run_conv(80, "c80", 1'b1);

        // Randomized operands over the full range and the in-range region
        for (int k = 0; k < 40; k++) begin
            case (k % 3)
                0:       v = int'($urandom_range(0, 65535));
                1:       v = int'($urandom_range(0, MAXV));
                default: v = int'($urandom_range(0, 120));
            endcase
            run_conv(v, $sformatf("rnd%0d", k), k < 8);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
